tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 91 +++++++++
 tb/tb_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter that serialises one of two requesters' messages
// into a paced byte stream for a UART transmitter.
module tx_arbiter #(
    parameter int GAP_CYCLES = 20,
    parameter int MAX_LEN    = 14
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [3:0]           len0,
    input  logic [3:0]           len1,
    input  logic [MAX_LEN*8-1:0] msg0,
    input  logic [MAX_LEN*8-1:0] msg1,
    input  logic                 tx_sent,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic                 busy,
    output logic [7:0]           tx_data,
    output logic                 tx_wr_en
);
    localparam int MW = MAX_LEN * 8;
    localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, SEND_WAIT, GAP} state_t;
    state_t         state;
    logic           sel;
    logic           last;
    logic [MW-1:0]  shreg;
    logic [3:0]     rem;
    logic [CW-1:0]  cnt;
    logic           win;
    logic [3:0]     len_w;
    logic [3:0]     len_c;
    always_comb begin
        win   = (req0 && req1) ? ~last : req1;
        len_w = win ? len1 : len0;
        len_c = (len_w > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len_w;
    end
    assign busy = (state != IDLE);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last     <= 1'b1;
            shreg    <= '0;
            rem      <= '0;
            cnt      <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            tx_data  <= 8'h00;
            tx_wr_en <= 1'b0;
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            tx_wr_en <= 1'b0;
            case (state)
                // a req still high during the done pulse belongs to the finished message
                IDLE: if ((req0 || req1) && !done0 && !done1) begin
                    sel   <= win;
                    last  <= win;
                    shreg <= win ? msg1 : msg0;
                    rem   <= len_c;
                    gnt0  <= ~win;
                    gnt1  <= win;
                    state <= SEND_WAIT;
                end
                SEND_WAIT: if (rem == 4'd0) begin
                    done0 <= ~sel;
                    done1 <= sel;
                    state <= IDLE;
                end else if (tx_sent) begin
                    tx_data  <= shreg[MW-1 -: 8];
                    tx_wr_en <= 1'b1;
                    shreg    <= shreg << 8;
                    rem      <= rem - 4'd1;
                    cnt      <= '0;
                    state    <= GAP;
                end
                GAP: if (cnt == CW'(GAP_CYCLES - 1)) state <= SEND_WAIT;
                     else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: randomized scenarios checked against an event-timing model of the arbiter.
module tb_tx_arbiter;
    localparam int GAP = 20;
    localparam int ML  = 14;
    localparam int MW  = ML * 8;
    localparam int TS  = 4096;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, tx_sent = 1'b0;
    logic [3:0]    len0 = '0, len1 = '0;
    logic [MW-1:0] msg0 = '0, msg1 = '0;
    logic          gnt0, gnt1, done0, done1, busy, tx_wr_en;
    logic [7:0]    tx_data;
    int            vectors = 0, miscompares = 0, cyc = 0;
    bit            rr_last = 1'b1;

    always #5 clk = ~clk;

    tx_arbiter #(.GAP_CYCLES(GAP), .MAX_LEN(ML)) dut (
        .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
        .len0(len0), .len1(len1), .msg0(msg0), .msg1(msg1), .tx_sent(tx_sent),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
        .tx_data(tx_data), .tx_wr_en(tx_wr_en)
    );

    function automatic logic [MW-1:0] rnd_msg();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[MW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            req0 = 1'b0; req1 = 1'b0; tx_sent = 1'b1;
            @(negedge clk);
            vectors++;
            if ({gnt0, gnt1, done0, done1, tx_wr_en, busy} !== 6'b0) begin
                miscompares++;
                $display("FAIL idle: gnt0,gnt1,done0,done1,wr,busy=%b want 000000",
                         {gnt0, gnt1, done0, done1, tx_wr_en, busy});
            end
        end
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick();
        reset_n = 1'b1;
        rr_last = 1'b1;
    endtask

    // Predicts grant/byte/done cycles from the arbitration rules, then runs the DUT and compares.
    task automatic run_txn(input string tag, input bit r0, input bit r1,
                           input logic [3:0] l0, input logic [3:0] l1,
                           input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                           input int pct, input int st_lo, input int st_hi);
        bit ts [TS];
        int e_gc[$], e_gi[$], e_dc[$], e_di[$], e_wc[$];
        int o_gc[$], o_gi[$], o_dc[$], o_di[$], o_wc[$];
        logic [7:0] e_wd[$], o_wd[$];
        logic [MW-1:0] m;
        bit p0, p1, w, f0, f1, g0, g1, eb, bchk, xchk;
        int t, c, n, s, rel;
        for (int i = 0; i < TS; i++) ts[i] = ($urandom_range(99) < pct) && !(i >= st_lo && i < st_hi);
        p0 = r0; p1 = r1; t = 0;
        while (p0 || p1) begin
            w = (p0 && p1) ? !rr_last : p1;
            rr_last = w;
            n = w ? int'(l1) : int'(l0);
            if (n > ML) n = ML;
            m = w ? m1 : m0;
            e_gc.push_back(t + 1); e_gi.push_back(int'(w));
            c = t + 1;
            for (int k = 0; k < n; k++) begin
                while (c < TS - 1 && !ts[c]) c++;
                e_wc.push_back(c + 1); e_wd.push_back(m[MW-1-8*k -: 8]);
                c = c + 1 + GAP;
            end
            e_dc.push_back(c + 1); e_di.push_back(int'(w));
            if (w) p1 = 1'b0; else p0 = 1'b0;
            t = c + 2;
        end
        f0 = 0; f1 = 0; g0 = 0; g1 = 0; bchk = 1; xchk = 1;
        s = cyc + 1;
        while (1) begin
            tick();
            rel = cyc - s;
            req0 = r0 && !f0; req1 = r1 && !f1;
            if (rel == 0) begin len0 = l0; len1 = l1; msg0 = m0; msg1 = m1; end
            if (g0) begin len0 = 4'($urandom()); msg0 = rnd_msg(); end
            if (g1) begin len1 = 4'($urandom()); msg1 = rnd_msg(); end
            tx_sent = ts[rel];
            @(negedge clk);
            if (gnt0) begin o_gc.push_back(rel); o_gi.push_back(0); g0 = 1; end
            if (gnt1) begin o_gc.push_back(rel); o_gi.push_back(1); g1 = 1; end
            if (done0) begin o_dc.push_back(rel); o_di.push_back(0); f0 = 1; end
            if (done1) begin o_dc.push_back(rel); o_di.push_back(1); f1 = 1; end
            if (tx_wr_en) begin o_wc.push_back(rel); o_wd.push_back(tx_data); end
            eb = 0;
            foreach (e_gc[i]) if (rel >= e_gc[i] && rel < e_dc[i]) eb = 1;
            if (bchk) begin
                vectors++;
                if (busy !== eb) begin
                    miscompares++; bchk = 0;
                    $display("FAIL %s busy@%0d: got %b want %b", tag, rel, busy, eb);
                end
            end
            if (xchk) begin
                vectors++;
                if ((gnt0 && gnt1) || (done0 && done1)) begin
                    miscompares++; xchk = 0;
                    $display("FAIL %s exclusive@%0d: gnt=%b%b done=%b%b want no pair high",
                             tag, rel, gnt0, gnt1, done0, done1);
                end
            end
            if ((f0 || !r0) && (f1 || !r1)) break;
            if (rel >= TS - 2) begin
                vectors++; miscompares++;
                $display("FAIL %s timeout: got no final done within %0d cycles, want done", tag, rel);
                break;
            end
        end
        vectors++;
        if (o_gc.size() != e_gc.size()) begin
            miscompares++;
            $display("FAIL %s gnt_count: got %0d want %0d", tag, o_gc.size(), e_gc.size());
        end
        for (int i = 0; i < o_gc.size() && i < e_gc.size(); i++) begin
            vectors++;
            if (o_gc[i] !== e_gc[i] || o_gi[i] !== e_gi[i]) begin
                miscompares++;
                $display("FAIL %s gnt[%0d]: got cyc=%0d id=%0d want cyc=%0d id=%0d",
                         tag, i, o_gc[i], o_gi[i], e_gc[i], e_gi[i]);
            end
        end
        vectors++;
        if (o_dc.size() != e_dc.size()) begin
            miscompares++;
            $display("FAIL %s done_count: got %0d want %0d", tag, o_dc.size(), e_dc.size());
        end
        for (int i = 0; i < o_dc.size() && i < e_dc.size(); i++) begin
            vectors++;
            if (o_dc[i] !== e_dc[i] || o_di[i] !== e_di[i]) begin
                miscompares++;
                $display("FAIL %s done[%0d]: got cyc=%0d id=%0d want cyc=%0d id=%0d",
                         tag, i, o_dc[i], o_di[i], e_dc[i], e_di[i]);
            end
        end
        vectors++;
        if (o_wc.size() != e_wc.size()) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d want %0d", tag, o_wc.size(), e_wc.size());
        end
        for (int i = 0; i < o_wc.size() && i < e_wc.size(); i++) begin
            vectors++;
            if (o_wc[i] !== e_wc[i] || o_wd[i] !== e_wd[i]) begin
                miscompares++;
                $display("FAIL %s write[%0d]: got cyc=%0d data=%h want cyc=%0d data=%h",
                         tag, i, o_wc[i], o_wd[i], e_wc[i], e_wd[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 4'd3; len1 = 4'd5;
        msg0 = rnd_msg(); msg1 = rnd_msg(); tx_sent = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            vectors++;
            if ({gnt0, gnt1, done0, done1, tx_wr_en, busy} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, tx_wr_en, busy});
            end
            vectors++;
            if (tx_data !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_data: got %h want 00", tx_data);
            end
        end
        tick();
        reset_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        rr_last = 1'b1;
        idle(2);
    endtask

    task automatic test_single();
        int gc = -1, wc = -1, dc = -1, nw = 0, s = 0;
        logic [7:0] wd = '0;
        for (int i = 0; i < GAP + 10; i++) begin
            tick();
            if (i == 0) s = cyc;
            req0 = (dc < 0); req1 = 1'b0; len0 = 4'd1; tx_sent = 1'b1;
            if (i == 0) msg0 = {8'h35, 104'h0};
            @(negedge clk);
            if (gnt0 && gc < 0) gc = cyc - s;
            if (tx_wr_en) begin nw++; if (wc < 0) begin wc = cyc - s; wd = tx_data; end end
            if (done0 && dc < 0) dc = cyc - s;
        end
        rr_last = 1'b0;
        vectors++;
        if (gc !== 1) begin miscompares++; $display("FAIL single_gnt: got cyc %0d want 1", gc); end
        vectors++;
        if (wc !== 2) begin miscompares++; $display("FAIL single_wr: got cyc %0d want 2", wc); end
        vectors++;
        if (wd !== 8'h35) begin miscompares++; $display("FAIL single_data: got %h want 35", wd); end
        vectors++;
        if (nw !== 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", nw); end
        vectors++;
        if (dc !== 2 + GAP + 1) begin miscompares++; $display("FAIL single_done: got cyc %0d want %0d", dc, 2 + GAP + 1); end
        idle(2);
    endtask

    task automatic test_tie();
        do_reset();
        run_txn("tie", 1, 1, 4'd1, 4'd14, {8'h35, 104'h0},
                112'h0D0A2B2820303030302029203A20, 100, 0, 0);
        idle(2);
    endtask

    task automatic test_stall();
        run_txn("stall", 0, 1, 4'd0, 4'd1, '0, rnd_msg(), 100, 1, 51);
        idle(2);
    endtask

    task automatic test_len_bounds();
        run_txn("len_zero", 0, 1, 4'd0, 4'd0, '0, rnd_msg(), 50, 0, 0);
        idle(2);
        run_txn("len_15", 0, 1, 4'd0, 4'd15, '0, rnd_msg(), 100, 0, 0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_a", 1, 1, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), rnd_msg(), rnd_msg(), 80, 0, 0);
        run_txn("b2b_b", 1, 1, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)), rnd_msg(), rnd_msg(), 80, 0, 0);
        run_txn("b2b_c", 1, 0, 4'($urandom_range(1, 3)), 4'd0, rnd_msg(), rnd_msg(), 100, 0, 0);
        idle(2);
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 12; i++) begin
            v = $urandom_range(1, 3);
            run_txn("random", v[0], v[1], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    rnd_msg(), rnd_msg(), $urandom_range(30, 100), 0, 0);
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        tick();
        req0 = 1'b1; req1 = 1'b0; len0 = 4'd14; msg0 = rnd_msg(); tx_sent = 1'b1;
        for (int i = 0; i < 200 && nw < 3; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            if (tx_wr_en) nw++;
        end
        vectors++;
        if (nw !== 3) begin miscompares++; $display("FAIL mid_bytes: got %0d writes want 3", nw); end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({tx_wr_en, busy, gnt0, done0} !== 4'b0) begin
            miscompares++;
            $display("FAIL mid_reset: wr,busy,gnt0,done0 got %b want 0000", {tx_wr_en, busy, gnt0, done0});
        end
        vectors++;
        if (tx_data !== 8'h00) begin miscompares++; $display("FAIL mid_reset_data: got %h want 00", tx_data); end
        req0 = 1'b0;
        tick();
        reset_n = 1'b1;
        rr_last = 1'b1;
        idle(GAP + 5);
        run_txn("post_reset", 1, 0, 4'd2, 4'd0, rnd_msg(), '0, 100, 0, 0);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_stall();
        test_len_bounds();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
